// File: rtl/dsp_mac_pipe_if.sv
// Operand/result bundle for the three-stage multiply-accumulate pipeline.
// The slave side is the pipeline itself; the master side drives operands and observes results.
interface dsp_mac_pipe_if #(
  parameter int A_W = 25,
  parameter int B_W = 18,
  parameter int P_W = 48
);
  logic                  ce;
  logic                  in_valid;
  logic [1:0]            op;
  logic signed [A_W-1:0] A;
  logic signed [B_W-1:0] B;
  logic signed [P_W-1:0] C;
  logic                  out_valid;
  logic signed [P_W-1:0] P;
  logic                  ovf;

  modport master (
    output ce, in_valid, op, A, B, C,
    input  out_valid, P, ovf
  );

  modport slave (
    input  ce, in_valid, op, A, B, C,
    output out_valid, P, ovf
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Three-stage signed MUL/MAC/MADD/MSUB pipeline with overflow detection.
// Define DSP_MAC_SAT_EN to clamp overflowing results instead of wrapping them.
module dsp_mac_pipe #(
  parameter int A_W = 25,
  parameter int B_W = 18,
  parameter int P_W = 48
) (
  input  logic            clk,
  input  logic            rst,
  dsp_mac_pipe_if.slave   bus
);

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MAC  = 2'b01,
    OP_MADD = 2'b10,
    OP_MSUB = 2'b11
  } op_e;

  localparam int M_W = A_W + B_W;
  localparam logic signed [P_W-1:0] P_MAX = {1'b0, {(P_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] P_MIN = {1'b1, {(P_W-1){1'b0}}};

  logic signed [A_W-1:0] aS1_q;
  logic signed [B_W-1:0] bS1_q;
  logic signed [P_W-1:0] cS1_q;
  op_e                   opS1_q;
  logic                  validS1_q;

  logic signed [P_W-1:0] prodS2_q, prodS2_d;
  logic signed [P_W-1:0] cS2_q;
  op_e                   opS2_q;
  logic                  validS2_q;

  logic signed [P_W-1:0] accP_q, accP_d;
  logic                  ovf_q, ovf_d;
  logic                  outValid_q;

  logic [M_W-1:0]        prodRaw;
  logic signed [P_W:0]   prodExt, cExt, accExt, sumExt;
  logic                  sumOvf;

  // Both operands are sign-extended to the full product width first, so the
  // low M_W bits of the unsigned multiply equal the signed product.
  always_comb begin
    prodRaw  = {{B_W{aS1_q[A_W-1]}}, aS1_q} * {{A_W{bS1_q[B_W-1]}}, bS1_q};
    prodS2_d = P_W'($signed(prodRaw));
  end

  always_comb begin
    prodExt = (P_W+1)'(prodS2_q);
    cExt    = (P_W+1)'(cS2_q);
    accExt  = (P_W+1)'(accP_q);
    sumExt  = prodExt;
    case (opS2_q)
      OP_MUL:  sumExt = prodExt;
      OP_MAC:  sumExt = accExt + prodExt;
      OP_MADD: sumExt = cExt + prodExt;
      OP_MSUB: sumExt = cExt - prodExt;
      default: sumExt = prodExt;
    endcase
    sumOvf = sumExt[P_W] ^ sumExt[P_W-1];

    accP_d = accP_q;
    ovf_d  = ovf_q;
    if (validS2_q) begin
      ovf_d = sumOvf;
`ifdef DSP_MAC_SAT_EN
      if (sumOvf)
        accP_d = sumExt[P_W] ? P_MIN : P_MAX;
      else
        accP_d = sumExt[P_W-1:0];
`else
      accP_d = sumExt[P_W-1:0];
`endif
    end
  end

  // Reset wins over ce so in-flight beats are dropped even while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      aS1_q      <= '0;
      bS1_q      <= '0;
      cS1_q      <= '0;
      opS1_q     <= OP_MUL;
      validS1_q  <= 1'b0;
      prodS2_q   <= '0;
      cS2_q      <= '0;
      opS2_q     <= OP_MUL;
      validS2_q  <= 1'b0;
      accP_q     <= '0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else if (bus.ce) begin
      aS1_q      <= bus.A;
      bS1_q      <= bus.B;
      cS1_q      <= bus.C;
      opS1_q     <= op_e'(bus.op);
      validS1_q  <= bus.in_valid;
      prodS2_q   <= prodS2_d;
      cS2_q      <= cS1_q;
      opS2_q     <= opS1_q;
      validS2_q  <= validS1_q;
      accP_q     <= accP_d;
      ovf_q      <= ovf_d;
      outValid_q <= validS2_q;
    end
  end

  assign bus.P         = accP_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = outValid_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: single-beat vector table plus accumulate,
// stall, overflow and reset sequences with hand-computed results.
module tb_dsp_mac_pipe;
  localparam int A_W = 25;
  localparam int B_W = 18;
  localparam int P_W = 48;
  localparam int NV  = 12;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MAC  = 2'b01;
  localparam logic [1:0] OP_MADD = 2'b10;
  localparam logic [1:0] OP_MSUB = 2'b11;

  localparam logic [47:0] P_MAX  = 48'h7FFF_FFFF_FFFF;
  localparam logic [47:0] P_MIN  = 48'h8000_0000_0000;
  localparam logic [47:0] ACC_M  = 48'h00FF_FF7E_0001;
`ifdef DSP_MAC_SAT_EN
  localparam logic [47:0] EXP_MADD_OVF = P_MAX;
  localparam logic [47:0] EXP_MSUB_OVF = P_MIN;
  localparam logic [47:0] EXP_ACC_OVF  = P_MAX;
`else
  localparam logic [47:0] EXP_MADD_OVF = P_MIN;
  localparam logic [47:0] EXP_MSUB_OVF = P_MAX;
  localparam logic [47:0] EXP_ACC_OVF  = 48'h80FF_BE7E_0081;
`endif

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [24:0] a;
    logic [17:0] b;
    logic [47:0] c;
    logic [47:0] expP;
    logic        expOvf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   vecCount = 0;
  int   missCount = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  dsp_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) bus ();

  dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic applyStimulus(input logic ceIn, input logic vIn, input logic [1:0] opIn,
                               input logic [24:0] aIn, input logic [17:0] bIn, input logic [47:0] cIn);
    bus.ce       = ceIn;
    bus.in_valid = vIn;
    bus.op       = opIn;
    bus.A        = aIn;
    bus.B        = bIn;
    bus.C        = cIn;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, OP_MUL, 25'd0, 18'd0, 48'd0);
  endtask

  task automatic checkOutput(input string name, input logic expV, input logic [47:0] expP, input logic expOvf);
    vecCount++;
    if (bus.out_valid !== expV || bus.P !== expP || bus.ovf !== expOvf) begin
      missCount++;
      $display("[TB] FAIL %s: got out_valid=%0b P=%h ovf=%0b, expected out_valid=%0b P=%h ovf=%0b",
               name, bus.out_valid, bus.P, bus.ovf, expV, expP, expOvf);
    end
  endtask

  task automatic checkAcc(input int j);
    logic [63:0] prod64;
    if (j < 128) begin
      prod64 = 64'(j + 1) * 64'(ACC_M);
      checkOutput($sformatf("acc_ramp_%0d", j), 1'b1, prod64[47:0], 1'b0);
    end else begin
      checkOutput("acc_overflow", 1'b1, EXP_ACC_OVF, 1'b1);
    end
  endtask

  initial begin
    vecs[0]  = '{"mul_3_m4",    OP_MUL,  25'd3,         -18'sd4,     48'd0,              48'hFFFF_FFFF_FFF4, 1'b0};
    vecs[1]  = '{"madd_c",      OP_MADD, 25'd1,         18'd1,       48'h0000_0009_5514, 48'h0000_0009_5515, 1'b0};
    vecs[2]  = '{"msub_c",      OP_MSUB, 25'd2,         18'd3,       48'h0000_0009_5514, 48'h0000_0009_550E, 1'b0};
    vecs[3]  = '{"mul_m7_6",    OP_MUL,  -25'sd7,       18'd6,       48'h0000_0000_0123, 48'hFFFF_FFFF_FFD6, 1'b0};
    vecs[4]  = '{"mac_100_m2",  OP_MAC,  25'd100,       -18'sd2,     48'd0,              48'hFFFF_FFFF_FF0E, 1'b0};
    vecs[5]  = '{"madd_neg",    OP_MADD, -25'sd1,       -18'sd1,     48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000, 1'b0};
    vecs[6]  = '{"msub_pos",    OP_MSUB, 25'd4,         18'd5,       48'd0,              48'hFFFF_FFFF_FFEC, 1'b0};
    vecs[7]  = '{"mul_corner",  OP_MUL,  25'h0FF_FFFF,  18'h2_0000,  48'd0,              48'hFE00_0002_0000, 1'b0};
    vecs[8]  = '{"madd_ovf",    OP_MADD, 25'd1,         18'd1,       P_MAX,              EXP_MADD_OVF,       1'b1};
    vecs[9]  = '{"msub_ovf",    OP_MSUB, 25'd1,         18'd1,       P_MIN,              EXP_MSUB_OVF,       1'b1};
    vecs[10] = '{"madd_min_ok", OP_MADD, -25'sd1,       18'd1,       48'h8000_0000_0001, P_MIN,              1'b0};
    vecs[11] = '{"mul_m1_m1",   OP_MUL,  -25'sd1,       -18'sd1,     48'd999,            48'h0000_0000_0001, 1'b0};

    rst = 1'b1;
    idleCycle();
    idleCycle();
    checkOutput("reset_state", 1'b0, 48'd0, 1'b0);
    rst = 1'b0;

    // Isolated beats: each result appears on the third edge after it is sampled.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(1'b1, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
      idleCycle();
      idleCycle();
      checkOutput(vecs[i].name, 1'b1, vecs[i].expP, vecs[i].expOvf);
    end
    idleCycle();
    checkOutput("idle_hold", 1'b0, 48'h0000_0000_0001, 1'b0);

    applyStimulus(1'b1, 1'b1, OP_MUL, 25'd2, 18'd5, 48'd0);
    applyStimulus(1'b1, 1'b1, OP_MAC, 25'd3, 18'd3, 48'd0);
    idleCycle();
    checkOutput("acc_mul", 1'b1, 48'd10, 1'b0);
    applyStimulus(1'b1, 1'b1, OP_MAC, 25'd1, 18'd1, 48'd0);
    checkOutput("acc_mac1", 1'b1, 48'd19, 1'b0);
    idleCycle();
    checkOutput("acc_gap", 1'b0, 48'd19, 1'b0);
    idleCycle();
    checkOutput("acc_mac2", 1'b1, 48'd20, 1'b0);

    // Stall mid-stream while offering a beat that must never be taken.
    applyStimulus(1'b1, 1'b1, OP_MUL, 25'd1, 18'd1, 48'd0);
    applyStimulus(1'b1, 1'b1, OP_MAC, 25'd1, 18'd2, 48'd0);
    applyStimulus(1'b1, 1'b1, OP_MAC, 25'd1, 18'd3, 48'd0);
    checkOutput("ce_first", 1'b1, 48'd1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, OP_MAC, 25'd9, 18'd9, 48'd0);
      checkOutput($sformatf("ce_hold_%0d", k), 1'b1, 48'd1, 1'b0);
    end
    idleCycle();
    checkOutput("ce_resume1", 1'b1, 48'd3, 1'b0);
    idleCycle();
    checkOutput("ce_resume2", 1'b1, 48'd6, 1'b0);
    idleCycle();
    checkOutput("ce_drained", 1'b0, 48'd6, 1'b0);

    // Back-to-back MUL then 128 MACs of the same product; the last one overflows.
    for (int k = 0; k <= 128; k++) begin
      applyStimulus(1'b1, 1'b1, (k == 0) ? OP_MUL : OP_MAC, 25'h07F_FFFF, 18'h1_FFFF, 48'd0);
      if (k >= 2) checkAcc(k - 2);
    end
    idleCycle();
    checkAcc(127);
    idleCycle();
    checkAcc(128);

    // Reset with two beats in flight and the pipeline stalled.
    applyStimulus(1'b1, 1'b1, OP_MUL, 25'd7, 18'd7, 48'd0);
    applyStimulus(1'b1, 1'b1, OP_MUL, 25'd8, 18'd8, 48'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, OP_MUL, 25'd0, 18'd0, 48'd0);
    checkOutput("rst_flight", 1'b0, 48'd0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idleCycle();
      checkOutput($sformatf("rst_drain_%0d", k), 1'b0, 48'd0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, OP_MUL, 25'd5, 18'd5, 48'd0);
    idleCycle();
    idleCycle();
    checkOutput("post_rst_mul", 1'b1, 48'd25, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule

// File: doc/dsp_mac_pipe.md
DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 The block SHALL have the parameter A_W, default 25, meaning signed width of operand A.
REQ-002 The block SHALL have the parameter B_W, default 18, meaning signed width of operand B.
REQ-003 The block SHALL have the parameter P_W, default 48, meaning signed width of the C operand and of the result; legal only when P_W >= A_W+B_W.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have the port ce, input, 1 bit: pipeline clock enable.
REQ-007 The block SHALL have the port in_valid, input, 1 bit: the input beat is valid.
REQ-008 The block SHALL have the port op, input, 2 bits: 00 MUL, 01 MAC, 10 MADD, 11 MSUB.
REQ-009 The block SHALL have the ports A (input, A_W), B (input, B_W) and C (input, P_W): signed operands.
REQ-010 The block SHALL have the port out_valid, output, 1 bit: P is valid this cycle.
REQ-011 The block SHALL have the port P, output, P_W bits: signed result.
REQ-012 The block SHALL have the port ovf, output, 1 bit: signed overflow on this result.

Function
REQ-013 The pipeline SHALL have three register stages: S1 captures A, B, C, op and in_valid; S2 holds M = A*B (signed, sign-extended to P_W), C, op and valid; S3 is the P/ovf/out_valid register.
REQ-014 Latency SHALL be 3 cycles: in_valid sampled at edge N (with ce=1 at edges N, N+1, N+2) gives out_valid=1 after edge N+2.
REQ-015 S3 SHALL compute, on a valid beat, MUL P=M; MAC P=P_prev+M; MADD P=C+M; MSUB P=C-M. P_prev is the current S3 P register.
REQ-016 S3 SHALL hold P and ovf unchanged when its stage is not valid; out_valid SHALL be 0 on such cycles.
REQ-017 Accumulation SHALL start with a MUL beat; MAC beats then accumulate, and an invalid beat between MAC beats SHALL NOT disturb the sum.
REQ-018 With ce=0, all stages including valid bits SHALL hold; out_valid SHALL hold its prior value and no accumulation SHALL occur.
REQ-019 The ALU SHALL use P_W+1-bit signed arithmetic; ovf SHALL be 1 when the exact result lies outside the signed P_W range, and it SHALL be updated only on valid S3 beats.
REQ-020 Without saturation, P SHALL be the low P_W bits of the result (two's-complement wrap).
REQ-021 Back-to-back valid beats SHALL sustain a throughput of one result per cycle, with mixed ops permitted per beat.

Reset
REQ-022 rst=1 at an edge SHALL clear every stage: valid bits, P=0, ovf=0, out_valid=0.
REQ-023 rst SHALL take priority over ce; beats in flight at reset SHALL be discarded and never emerge.
REQ-024 The first output after reset SHALL be the product of the first beat accepted after reset deasserts.

Configuration
REQ-025 The macro DSP_MAC_SAT_EN SHALL select saturation: when it is defined, an overflowing result SHALL clamp P to 2^(P_W-1)-1 or -2^(P_W-1), according to the sign of the exact result, with ovf=1; when it is undefined, REQ-020 wrap behaviour applies, with ovf still reported.

Verification
REQ-026 The bench SHALL check reset then a MUL beat with A=3, B=-4: out_valid=1 exactly 3 cycles later, with P=-12 and ovf=0.
REQ-027 The bench SHALL check MUL(2,5) followed by MAC(3,3), an idle cycle, then MAC(1,1): P sequence 10, 19, 20; out_valid low during the gap with P held at 19.
REQ-028 The bench SHALL check MADD with C=0x0000_0009_5514, A=1, B=1 (giving P=0x0000_0009_5515), then MSUB with the same C and A=2, B=3 (giving P=0x0000_0009_550E).
REQ-029 The bench SHALL check MUL(0x7FFFFF, 0x1FFFF) followed by repeated MAC of the same operands until overflow: without DSP_MAC_SAT_EN, P wraps negative and ovf=1; with it, P=0x7FFF_FFFF_FFFF and ovf=1.
REQ-030 The bench SHALL check ce=0 for 4 cycles mid-stream: no output changes and no accumulation, then on release the results resume in order.
REQ-031 The bench SHALL check rst asserted with 2 beats in flight (and with ce=0): P=0 and out_valid=0 next cycle, and neither beat ever appears.
